// File: rtl/dffram_ctrl.sv
// -----------------------------------------------------------------------------
// dffram_ctrl
//
// Flip-flop RAM behind an 8-bit pin-level command interface. The host never
// presents an address bus: it loads a word address with SET_ADDR and then
// streams bytes in or out. Each byte access moves an internal byte-lane
// pointer forward, and the word address advances when the pointer passes the
// last lane. A FILL command starts a hardware engine that writes one whole
// word per cycle until every word holds the fill byte.
//
// Parameters:
//   WORD_BYTES  bytes per word (1..8)
//   DEPTH       number of words, power of two (2..256)
//   AW          address width, log2(DEPTH); derived, not user-set
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset; memory contents are kept
//   cmd_valid   command strobe, sampled every cycle
//   cmd         opcode: 00 SET_ADDR, 01 WRITE_BYTE, 10 READ_BYTE, 11 FILL
//   din         command operand
//   dout        registered read data, held until the next read or reset
//   dout_valid  one-cycle pulse when dout carries new read data
//   busy        high while a FILL runs; commands are dropped meanwhile
//   addr_out    current word address
//
// Handshake: a command is taken on the rising edge where cmd_valid=1 and
// busy=0. There is no back-pressure other than busy; a command presented
// while busy is dropped without effect and is not retried.
// -----------------------------------------------------------------------------
module dffram_ctrl #(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 32,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          dout_valid,
  output logic          busy,
  output logic [AW-1:0] addr_out
);

  localparam int WW = 8 * WORD_BYTES;
  // A one-lane word still gets a 1-bit pointer so the port widths stay legal;
  // it simply never leaves zero.
  localparam int PW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [1:0] OP_SET_ADDR = 2'b00;
  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] OP_READ     = 2'b10;
  localparam logic [1:0] OP_FILL     = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   fill_addr_q, fill_addr_d;
  logic [7:0]      fill_byte_q, fill_byte_d;
  logic [7:0]      dout_q;
  logic            dout_valid_q;

  // Storage flops carry no reset: a reset in the middle of a fill must leave
  // both filled and not-yet-filled words as they were.
  logic [WW-1:0]   mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Pointer advance and lane decode
  // ---------------------------------------------------------------------------
  logic                  last_lane;
  logic [PW-1:0]         ptr_inc;
  logic [AW-1:0]         addr_inc;
  logic [WORD_BYTES-1:0] lane_sel;

  always_comb begin
    last_lane = (ptr_q == PW'(WORD_BYTES - 1));
    ptr_inc   = last_lane ? '0 : ptr_q + PW'(1);
    // DEPTH is a power of two, so the AW-bit add wraps word DEPTH-1 to 0.
    addr_inc  = last_lane ? addr_q + AW'(1) : addr_q;
    lane_sel  = '0;
    for (int l = 0; l < WORD_BYTES; l++) begin
      lane_sel[l] = (ptr_q == PW'(l));
    end
  end

  // ---------------------------------------------------------------------------
  // Read lane mux
  // ---------------------------------------------------------------------------
  logic [WW-1:0] rd_word;
  logic [7:0]    rd_byte;

  always_comb begin
    rd_word = mem[addr_q];
    rd_byte = '0;
    for (int l = 0; l < WORD_BYTES; l++) begin
      if (lane_sel[l]) begin
        rd_byte = rd_word[8*l +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and memory-port control
  // ---------------------------------------------------------------------------
  logic                  rd_en;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [7:0]            wr_byte;
  logic [WORD_BYTES-1:0] wr_be;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ptr_d       = ptr_q;
    fill_addr_d = fill_addr_q;
    fill_byte_d = fill_byte_q;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = addr_q;
    wr_byte     = din;
    wr_be       = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd)
            OP_SET_ADDR: begin
              addr_d = din[AW-1:0];
              ptr_d  = '0;
            end
            OP_WRITE: begin
              wr_en  = 1'b1;
              wr_be  = lane_sel;
              addr_d = addr_inc;
              ptr_d  = ptr_inc;
            end
            OP_READ: begin
              rd_en  = 1'b1;
              addr_d = addr_inc;
              ptr_d  = ptr_inc;
            end
            OP_FILL: begin
              fill_byte_d = din;
              fill_addr_d = '0;
              state_d     = ST_FILL;
            end
            default: ;
          endcase
        end
      end

      ST_FILL: begin
        // One full word per cycle, fill byte replicated across every lane.
        wr_en       = 1'b1;
        wr_addr     = fill_addr_q;
        wr_byte     = fill_byte_q;
        wr_be       = '1;
        fill_addr_d = fill_addr_q + AW'(1);
        if (fill_addr_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          addr_d  = '0;
          ptr_d   = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      ptr_q        <= '0;
      fill_addr_q  <= '0;
      fill_byte_q  <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      ptr_q        <= ptr_d;
      fill_addr_q  <= fill_addr_d;
      fill_byte_q  <= fill_byte_d;
      dout_valid_q <= rd_en;
      if (rd_en) begin
        dout_q <= rd_byte;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. Reset suppresses the write so a reset edge landing mid-fill
  // does not touch the word the engine was about to write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int l = 0; l < WORD_BYTES; l++) begin
        if (wr_be[l]) begin
          mem[wr_addr][8*l +: 8] <= wr_byte;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q == ST_FILL);
  assign addr_out   = addr_q;

endmodule

// File: tb/tb_dffram_ctrl.sv
`timescale 1ns/1ps
module tb_dffram_ctrl;

  localparam logic [1:0] OP_SET  = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_FILL = 2'b11;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: 4 bytes x 32 words
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       dout_valid;
  logic       busy;
  logic [4:0] addr_out;

  dffram_ctrl #(.WORD_BYTES(4), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .din(din),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .addr_out(addr_out)
  );

  // Small instance: 1 byte x 4 words
  logic       cmd_valid_s = 1'b0;
  logic [1:0] cmd_s = 2'b00;
  logic [7:0] din_s = 8'h00;
  logic [7:0] dout_s;
  logic       dout_valid_s;
  logic       busy_s;
  logic [1:0] addr_out_s;

  dffram_ctrl #(.WORD_BYTES(1), .DEPTH(4)) dut_s (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_s), .cmd(cmd_s), .din(din_s),
    .dout(dout_s), .dout_valid(dout_valid_s), .busy(busy_s), .addr_out(addr_out_s)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [31:0] model_mem[32];

  // Every read pushes its expected byte together with the cycle in which
  // dout_valid must be high; the monitor checks both.
  always @(negedge clk) begin
    if (dout_valid || (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc)) begin
      checks++;
      if (exp_cyc_q.size() == 0 || exp_cyc_q[0] != cyc) begin
        errors++;
        $display("FAIL unexpected_dout_valid: got dout_valid=%b dout=%h, expected no read data (cycle %0d)",
                 dout_valid, dout, cyc);
      end else if (dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL missing_dout_valid: got dout_valid=%b, expected 1 with dout=%h (cycle %0d)",
                 dout_valid, exp_q[0], cyc);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end else begin
        if (dout !== exp_q[0]) begin
          errors++;
          $display("FAIL read_data: got %h, expected %h (cycle %0d)", dout, exp_q[0], cyc);
        end
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send(input logic [1:0] op, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd       = op;
    din       = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_s(input logic [1:0] op, input logic [7:0] d);
    cmd_valid_s = 1'b1;
    cmd_s       = op;
    din_s       = d;
    @(posedge clk);
    #1;
    cmd_valid_s = 1'b0;
  endtask

  task automatic read_exp(input logic [7:0] e);
    send(OP_RD, 8'h00);
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc);
  endtask

  task automatic read_word_exp(input logic [31:0] w);
    read_exp(w[7:0]);
    read_exp(w[15:8]);
    read_exp(w[23:16]);
    read_exp(w[31:24]);
  endtask

  task automatic run_fill(input logic [7:0] d, output int cnt);
    send(OP_FILL, d);
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (dout !== 8'h00)     begin errors++; $display("FAIL reset_dout: got %h, expected 00", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b, expected 0", dout_valid); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (addr_out !== 5'd0)   begin errors++; $display("FAIL reset_addr: got %0d, expected 0", addr_out); end
    checks++; if (dout_s !== 8'h00)    begin errors++; $display("FAIL reset_dout_s: got %h, expected 00", dout_s); end
    checks++; if (busy_s !== 1'b0)     begin errors++; $display("FAIL reset_busy_s: got %b, expected 0", busy_s); end
    checks++; if (addr_out_s !== 2'd0) begin errors++; $display("FAIL reset_addr_s: got %0d, expected 0", addr_out_s); end
    rst = 1'b0;
  endtask

  task automatic test_byte_rw();
    send(OP_SET, 8'd5);
    send(OP_WR, 8'h11);
    send(OP_WR, 8'h22);
    send(OP_WR, 8'h33);
    send(OP_WR, 8'h44);
    send(OP_SET, 8'd5);
    read_exp(8'h11);
    read_exp(8'h22);
    read_exp(8'h33);
    read_exp(8'h44);
    @(negedge clk);
    checks++;
    if (addr_out !== 5'd6) begin errors++; $display("FAIL byte_rw_addr: got %0d, expected 6", addr_out); end
  endtask

  task automatic test_wrap();
    send(OP_SET, 8'd31);
    for (int i = 0; i < 5; i++) send(OP_WR, 8'hA0 + 8'(i));
    @(negedge clk);
    checks++;
    if (addr_out !== 5'd0) begin errors++; $display("FAIL wrap_addr: got %0d, expected 0", addr_out); end
    // With ptr=1 this byte must land in word 0 lane 1.
    send(OP_WR, 8'hA5);
    send(OP_SET, 8'd31);
    read_word_exp(32'hA3A2A1A0);
    read_exp(8'hA4);
    read_exp(8'hA5);
  endtask

  task automatic test_lane_iso();
    int cnt;
    run_fill(8'hFF, cnt);
    checks++;
    if (cnt != 32) begin errors++; $display("FAIL lane_iso_fill_len: got %0d, expected 32", cnt); end
    send(OP_SET, 8'd2);
    send(OP_WR, 8'h00);
    send(OP_SET, 8'd2);
    read_word_exp(32'hFFFFFF00);
  endtask

  task automatic test_fill_busy();
    int cnt;
    send(OP_SET, 8'd3);
    send(OP_FILL, 8'h5A);
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      // Word 3 is already filled by now, so a write that slipped through
      // would be visible afterwards.
      if (cnt == 20) begin
        cmd_valid = 1'b1; cmd = OP_WR; din = 8'h00;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (cnt != 32) begin errors++; $display("FAIL fill_busy_len: got %0d, expected 32", cnt); end
    checks++;
    if (addr_out !== 5'd0) begin errors++; $display("FAIL fill_addr_after: got %0d, expected 0", addr_out); end
    // Command immediately in the first non-busy cycle.
    send(OP_SET, 8'd0);
    for (int w = 0; w < 32; w++) read_word_exp(32'h5A5A5A5A);
  endtask

  task automatic test_reset_mid_fill();
    int cnt;
    run_fill(8'hFF, cnt);
    checks++;
    if (cnt != 32) begin errors++; $display("FAIL rmf_prefill_len: got %0d, expected 32", cnt); end
    send(OP_FILL, 8'h00);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rmf_busy_before: got %b, expected 1", busy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rmf_busy: got %b, expected 0", busy); end
    checks++; if (dout !== 8'h00)    begin errors++; $display("FAIL rmf_dout: got %h, expected 00", dout); end
    checks++; if (addr_out !== 5'd0) begin errors++; $display("FAIL rmf_addr: got %0d, expected 0", addr_out); end
    send(OP_SET, 8'd0);
    for (int w = 0; w < 32; w++) begin
      model_mem[w] = (w < 10) ? 32'h00000000 : 32'hFFFFFFFF;
      read_word_exp(model_mem[w]);
    end
  endtask

  task automatic test_random();
    int a;
    logic [31:0] w;
    for (int n = 0; n < 6; n++) begin
      a = $urandom_range(0, 31);
      w = $urandom;
      send(OP_SET, 8'(a));
      send(OP_WR, w[7:0]);
      send(OP_WR, w[15:8]);
      send(OP_WR, w[23:16]);
      send(OP_WR, w[31:24]);
      model_mem[a] = w;
    end
    send(OP_SET, 8'd0);
    for (int i = 0; i < 32; i++) read_word_exp(model_mem[i]);
  endtask

  task automatic test_small();
    logic [7:0] exp_s[4];
    int cnt;
    exp_s[0] = 8'h05; exp_s[1] = 8'h02; exp_s[2] = 8'h03; exp_s[3] = 8'h04;
    send_s(OP_SET, 8'd0);
    for (int i = 1; i <= 5; i++) send_s(OP_WR, 8'(i));
    @(negedge clk);
    checks++;
    if (addr_out_s !== 2'd1) begin errors++; $display("FAIL small_addr: got %0d, expected 1", addr_out_s); end
    send_s(OP_SET, 8'd0);
    for (int i = 0; i < 4; i++) begin
      send_s(OP_RD, 8'h00);
      @(negedge clk);
      checks++;
      if (dout_valid_s !== 1'b1 || dout_s !== exp_s[i]) begin
        errors++;
        $display("FAIL small_read%0d: got valid=%b data=%h, expected valid=1 data=%h",
                 i, dout_valid_s, dout_s, exp_s[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (dout_valid_s !== 1'b0) begin errors++; $display("FAIL small_valid_pulse: got %b, expected 0", dout_valid_s); end
    send_s(OP_FILL, 8'h77);
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!busy_s) break;
      cnt++;
    end
    checks++;
    if (cnt != 4) begin errors++; $display("FAIL small_fill_len: got %0d, expected 4", cnt); end
    send_s(OP_SET, 8'd1);
    send_s(OP_RD, 8'h00);
    @(negedge clk);
    checks++;
    if (dout_valid_s !== 1'b1 || dout_s !== 8'h77) begin
      errors++;
      $display("FAIL small_fill_read: got valid=%b data=%h, expected valid=1 data=77", dout_valid_s, dout_s);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_byte_rw();
    test_wrap();
    test_lane_iso();
    test_fill_busy();
    test_reset_mid_fill();
    test_random();
    test_small();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
